// File: rtl/mult_sched_if.sv
// Bundles the requester, multiplier and response channels of mult_sched.
// The scheduler connects through the slave modport; its environment
// (requesters, multiplier, response sink) uses the master modport.
interface mult_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;

  logic [7:0]        mult_a;
  logic [7:0]        mult_b;
  logic              mult_start;
  logic              done_mult;
  logic [15:0]       result_mult;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_result;
  logic              rsp_err;

  logic              spurious_done;

  modport slave (
    input  req_valid, req_a, req_b, done_mult, result_mult, rsp_ready,
    output req_ready, mult_a, mult_b, mult_start,
           rsp_valid, rsp_id, rsp_result, rsp_err, spurious_done
  );

  modport master (
    output req_valid, req_a, req_b, done_mult, result_mult, rsp_ready,
    input  req_ready, mult_a, mult_b, mult_start,
           rsp_valid, rsp_id, rsp_result, rsp_err, spurious_done
  );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one multi-cycle 8x8 multiplier among NREQ
// requesters. One operation is in flight at a time: accept (IDLE), start
// pulse (ISSUE), wait for done or watchdog expiry (WAIT), hold the response
// until it is taken (RESP).
module mult_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  mult_sched_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [7:0]      r_mult_a;
  logic [7:0]      r_mult_b;
  logic [7:0]      r_cnt;
  logic [15:0]     r_rsp_result;
  logic            r_rsp_err;
  logic            r_spurious;

  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_idx;
  logic [NREQ-1:0] w_req_ready;
  logic            w_accept;
  logic            w_timeout;
  logic            w_handshake;
  logic [7:0]      w_sel_a;
  logic [7:0]      w_sel_b;

  // Round-robin winner: first valid requester at or after the pointer, wrapping.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = IDW'((int'(r_ptr) + i) % NREQ);
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_sel_a     = bus.req_a[{w_win, 3'b000} +: 8];
  assign w_sel_b     = bus.req_b[{w_win, 3'b000} +: 8];
  assign w_accept    = (r_state == IDLE) && w_any;
  assign w_timeout   = (r_cnt == 8'(TIMEOUT - 1));
  assign w_handshake = (r_state == RESP) && bus.rsp_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and accept decode; done wins over a simultaneous timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_req_ready[w_win] = 1'b1;
          w_state_nxt        = ISSUE;
        end
      end
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (bus.done_mult || w_timeout) w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, watchdog, response capture, pointer and sticky flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_mult_a     <= '0;
      r_mult_b     <= '0;
      r_cnt        <= '0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
      r_spurious   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mult_a <= w_sel_a;
        r_mult_b <= w_sel_b;
        r_id     <= w_win;
      end

      if (r_state == ISSUE)     r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 8'd1;

      if (r_state == WAIT) begin
        if (bus.done_mult) begin
          r_rsp_result <= bus.result_mult;
          r_rsp_err    <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_result <= '0;
          r_rsp_err    <= 1'b1;
        end
      end

      if (w_handshake) begin
        r_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
      end

      if (bus.done_mult && (r_state != WAIT)) r_spurious <= 1'b1;
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.mult_a        = r_mult_a;
  assign bus.mult_b        = r_mult_b;
  assign bus.mult_start    = (r_state == ISSUE);
  assign bus.rsp_valid     = (r_state == RESP);
  assign bus.rsp_id        = r_id;
  assign bus.rsp_result    = r_rsp_result;
  assign bus.rsp_err       = r_rsp_err;
  assign bus.spurious_done = r_spurious;

endmodule
